// File: rtl/alu_sequencer_if.sv
// Instruction issue handshake between issue logic and alu_sequencer.
// master: issuer drives valid/op/rd/rs1/rs2; slave: sequencer drives ready.
interface alu_sequencer_if #(
  parameter int AW = 2
);
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_rd,
    output instr_rs1,
    output instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_rd,
    input  instr_rs1,
    input  instr_rs2,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle IDLE/READ/EXEC/WB sequencer for an external one-hot ALU.
// Ports: clk, rst_n, instr (slave handshake), ALU bus, load, debug read, done.
module alu_sequencer #(
  parameter  int DW    = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sequencer_if.slave instr,
  output logic [7:0]    alu_op_onehot,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_flag,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_sel,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [DW-1:0] done_result,
  output logic          flag
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [DW-1:0] res_q;
  logic          flg_q;
  logic [DW-1:0] regs [NREGS];
  logic          accept;

  assign accept  = instr.instr_valid & instr.instr_ready;
  assign rd_data = regs[rd_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    instr.instr_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr.instr_ready = 1'b1;
        if (instr.instr_valid) state_d = READ;
      end
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      res_q         <= '0;
      flg_q         <= 1'b0;
      alu_op_onehot <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      done          <= 1'b0;
      done_result   <= '0;
      flag          <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      done          <= 1'b0;
      alu_op_onehot <= '0;
      unique case (state_q)
        IDLE: begin
          // A load in the accept cycle lands before READ samples regs.
          if (ld_en) regs[ld_addr] <= ld_data;
          if (accept) begin
            op_q  <= instr.instr_op;
            rd_q  <= instr.instr_rd;
            rs1_q <= instr.instr_rs1;
            rs2_q <= instr.instr_rs2;
          end
        end
        READ: begin
          alu_a         <= regs[rs1_q];
          alu_b         <= regs[rs2_q];
          // Registered so the opcode is high for exactly the EXEC cycle.
          alu_op_onehot <= 8'b1 << op_q;
        end
        EXEC: begin
          res_q <= alu_result;
          flg_q <= alu_flag;
        end
        WB: begin
          regs[rd_q]  <= res_q;
          done        <= 1'b1;
          done_result <= res_q;
          // Logic ops (AND/OR/NOT) leave the status flag alone.
          if (op_q <= 3'd4) flag <= flg_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural one-hot ALU.
// Table-driven instruction vectors plus handshake/load/reset sequences.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_op_onehot;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_flag;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       done;
  logic [7:0] done_result;
  logic       flag;

  int checks = 0;
  int errors = 0;

  alu_sequencer_if #(.AW(2)) ifc ();

  alu_sequencer #(.DW(8), .NREGS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (ifc),
    .alu_op_onehot (alu_op_onehot),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .alu_flag      (alu_flag),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data),
    .done          (done),
    .done_result   (done_result),
    .flag          (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: carry for ADD/INC, borrow for SUB/DEC, 0 otherwise.
  logic [8:0] t9;
  always_comb begin
    t9         = '0;
    alu_result = '0;
    alu_flag   = 1'b0;
    case (alu_op_onehot)
      8'h01: alu_result = alu_a ^ alu_b;
      8'h02: begin
        t9         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = t9[7:0];
        alu_flag   = t9[8];
      end
      8'h04: begin
        alu_result = alu_a - alu_b;
        alu_flag   = alu_a < alu_b;
      end
      8'h08: begin
        alu_result = alu_a + 8'd1;
        alu_flag   = alu_a == 8'hff;
      end
      8'h10: begin
        alu_result = alu_a - 8'd1;
        alu_flag   = alu_a == 8'h00;
      end
      8'h20: alu_result = alu_a & alu_b;
      8'h40: alu_result = alu_a | alu_b;
      8'h80: alu_result = ~alu_a;
      default: ;
    endcase
  end

  typedef struct {
    logic       do_ld;
    logic [1:0] la;
    logic [7:0] lv;
    logic       do_ins;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] er;
    logic       ef;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] a,
                      input logic [7:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic peek(input string nm,
                      input logic [1:0] r,
                      input logic [7:0] exp);
    rd_sel = r;
    #1;
    chk(nm, rd_data, exp);
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [1:0] rd,
                       input logic [1:0] rs1,
                       input logic [1:0] rs2,
                       input logic [7:0] er,
                       input logic       ef,
                       input logic       with_ld,
                       input logic       mid_ld,
                       input logic [1:0] la,
                       input logic [7:0] lv);
    int got;
    logic [7:0] oh;
    oh = 8'b1 << op;
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = op;
    ifc.instr_rd    = rd;
    ifc.instr_rs1   = rs1;
    ifc.instr_rs2   = rs2;
    ld_en   = with_ld;
    ld_addr = la;
    ld_data = lv;
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
    ld_en = mid_ld;
    chk("ready_read", ifc.instr_ready, 0);
    chk("onehot_read", alu_op_onehot, 0);
    got = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        chk("onehot_exec", alu_op_onehot, oh);
        chk("ready_exec", ifc.instr_ready, 0);
      end
      if (c == 2)
        chk("onehot_wb", alu_op_onehot, 0);
      if (done) begin
        got = c;
        break;
      end
    end
    ld_en = 1'b0;
    chk("latency", got, 3);
    chk("done_result", done_result, er);
    chk("flag", flag, ef);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
    peek("rd_data_wb", rd, er);
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    logic [7:0] r1;
    logic [7:0] r2;

    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ndone;
    int t [2];
    logic [7:0] rr [2];

    vt[0]  = '{1, 0, 200, 0, 0, 0, 0, 0,   0, 0};
    vt[1]  = '{1, 1, 100, 1, 1, 2, 0, 1,  44, 1};
    vt[2]  = '{1, 0,   5, 0, 0, 0, 0, 0,   0, 0};
    vt[3]  = '{1, 1,   7, 1, 2, 3, 0, 1, 254, 1};
    vt[4]  = '{0, 0,   0, 1, 2, 3, 1, 0,   2, 0};
    vt[5]  = '{1, 0,   0, 1, 4, 0, 0, 0, 255, 1};
    vt[6]  = '{0, 0,   0, 1, 3, 0, 0, 0,   0, 1};
    vt[7]  = '{0, 0,   0, 1, 5, 1, 0, 0,   0, 1};
    vt[8]  = '{0, 0,   0, 1, 0, 2, 3, 1,   2, 0};
    vt[9]  = '{1, 1, 255, 1, 1, 0, 1, 2,   1, 1};
    vt[10] = '{0, 0,   0, 1, 6, 3, 1, 2, 255, 1};
    vt[11] = '{0, 0,   0, 1, 7, 2, 2, 2, 253, 1};

    rst_n           = 1'b0;
    ld_en           = 1'b0;
    ld_addr         = '0;
    ld_data         = '0;
    rd_sel          = '0;
    ifc.instr_valid = 1'b0;
    ifc.instr_op    = '0;
    ifc.instr_rd    = '0;
    ifc.instr_rs1   = '0;
    ifc.instr_rs2   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_ready", ifc.instr_ready, 1);
    chk("rst_onehot", alu_op_onehot, 0);
    chk("rst_done", done, 0);
    chk("rst_done_result", done_result, 0);
    chk("rst_flag", flag, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    for (int r = 0; r < 4; r++)
      peek("rst_reg", 2'(r), 0);

    for (int i = 0; i < 12; i++) begin
      if (vt[i].do_ld) load(vt[i].la, vt[i].lv);
      if (vt[i].do_ins)
        issue(vt[i].op, vt[i].rd, vt[i].rs1,
              vt[i].rs2, vt[i].er, vt[i].ef,
              1'b0, 1'b0, 2'd0, 8'd0);
    end

    // Regs now r0=1 r1=255 r2=253 r3=255, flag=1.
    // Second instruction held valid through READ..WB.
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = 3'd1;
    ifc.instr_rd    = 2'd0;
    ifc.instr_rs1   = 2'd0;
    ifc.instr_rs2   = 2'd0;
    @(posedge clk);
    #1;
    ifc.instr_op  = 3'd3;
    ifc.instr_rd  = 2'd1;
    ifc.instr_rs1 = 2'd1;
    ifc.instr_rs2 = 2'd1;
    ndone = 0;
    t[0] = 0;
    t[1] = 0;
    rr[0] = '0;
    rr[1] = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 1 || c == 2)
        chk("busy_ready", ifc.instr_ready, 0);
      if (c == 3)
        chk("idle_ready", ifc.instr_ready, 1);
      if (c == 4) begin
        chk("second_taken", ifc.instr_ready, 0);
        ifc.instr_valid = 1'b0;
      end
      if (done) begin
        if (ndone < 2) begin
          t[ndone]  = c;
          rr[ndone] = done_result;
        end
        ndone++;
      end
    end
    chk("b2b_ndone", ndone, 2);
    chk("b2b_t1", t[0], 3);
    chk("b2b_t2", t[1], 7);
    chk("b2b_res1", rr[0], 2);
    chk("b2b_res2", rr[1], 0);
    chk("b2b_flag", flag, 1);
    peek("b2b_r0", 2'd0, 2);
    peek("b2b_r1", 2'd1, 0);

    // Load held high in READ..WB must be ignored.
    issue(3'd6, 2'd3, 2'd1, 2'd1, 8'd0, 1'b1,
          1'b0, 1'b1, 2'd1, 8'd77);
    peek("busy_ld_r1", 2'd1, 0);

    // Load in the accept cycle is visible to READ.
    issue(3'd7, 2'd2, 2'd1, 2'd1, 8'd246, 1'b1,
          1'b1, 1'b0, 2'd1, 8'd9);
    peek("acc_ld_r1", 2'd1, 9);

    // Reset during EXEC of ADD r0 = r0 + r1.
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = 3'd1;
    ifc.instr_rd    = 2'd0;
    ifc.instr_rs1   = 2'd0;
    ifc.instr_rs2   = 2'd1;
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_exec_onehot", alu_op_onehot, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("abort_onehot", alu_op_onehot, 0);
    chk("abort_ready", ifc.instr_ready, 1);
    chk("abort_flag", flag, 0);
    chk("abort_done", done, 0);
    for (int r = 0; r < 4; r++)
      peek("abort_reg", 2'(r), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    peek("abort_r0", 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
